// File: rtl/regfile_writeback_ctrl_if.sv
// Producer-side result handshake for the register writeback controller.
// One valid/ready pair per producer with packed rd and data slices.
interface regfile_writeback_ctrl_if #(
    parameter int NUM_SRC        = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic [NUM_SRC-1:0]                src_valid;
    logic [NUM_SRC-1:0]                src_ready;
    logic [NUM_SRC*REG_ADDR_WIDTH-1:0] src_rd;
    logic [NUM_SRC*DATA_WIDTH-1:0]     src_data;

    modport master (
        output src_valid,
        output src_rd,
        output src_data,
        input  src_ready
    );

    modport slave (
        input  src_valid,
        input  src_rd,
        input  src_data,
        output src_ready
    );
endinterface

// File: rtl/regfile_writeback_ctrl.sv
// Merges producer results into the single register-table write port,
// with a pending-destination scoreboard and writeback bypass.
module regfile_writeback_ctrl #(
    parameter int NUM_SRC        = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    regfile_writeback_ctrl_if.slave   src,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic [REG_ADDR_WIDTH-1:0] query_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] query_rs2,
    output logic                      rs1_pending,
    output logic                      rs2_pending,
    output logic                      rs1_fwd_valid,
    output logic                      rs2_fwd_valid,
    output logic [DATA_WIDTH-1:0]     rs1_fwd_data,
    output logic [DATA_WIDTH-1:0]     rs2_fwd_data,
    output logic                      wb_en,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0]     wb_data
);
    localparam int NUM_REG = 1 << REG_ADDR_WIDTH;
    localparam int PW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cand_t;

    localparam cand_t NSRC = cand_t'(NUM_SRC);
    localparam ptr_t  LAST = ptr_t'(NUM_SRC - 1);

    logic [NUM_SRC-1:0]        full;
    logic [NUM_SRC-1:0]        grant;
    logic [NUM_SRC-1:0]        ready;
    logic [NUM_SRC-1:0]        accept;
    logic [REG_ADDR_WIDTH-1:0] ent_rd   [NUM_SRC];
    logic [DATA_WIDTH-1:0]     ent_data [NUM_SRC];
    logic [REG_ADDR_WIDTH-1:0] in_rd    [NUM_SRC];
    logic [DATA_WIDTH-1:0]     in_data  [NUM_SRC];

    ptr_t  ptr;
    ptr_t  gnt_idx;
    logic  gnt_any;
    cand_t cand;

    logic [NUM_REG-1:0] pending;
    logic [NUM_REG-1:0] pending_nxt;

    assign src.src_ready = ready;

    // Unpack producer slices; rd==0 results are taken but never buffered
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            in_rd[i]   = src.src_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            in_data[i] = src.src_data[i*DATA_WIDTH +: DATA_WIDTH];
            ready[i]   = ~reset & (~full[i] | grant[i]);
            accept[i]  = src.src_valid[i] & ready[i]
                       & (in_rd[i] != '0);
        end
    end

    // Round-robin pick: first full entry scanning from ptr upward
    always_comb begin
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = cand_t'(ptr) + cand_t'(k);
            if (cand >= NSRC) cand = cand - NSRC;
            if (!gnt_any && full[cand[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[PW-1:0];
            end
        end
        if (gnt_any) grant[gnt_idx] = 1'b1;
    end

    // Holding buffers: a refill on the granted port overrides the drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                ent_rd[i]   <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (accept[i]) begin
                    full[i]     <= 1'b1;
                    ent_rd[i]   <= in_rd[i];
                    ent_data[i] <= in_data[i];
                end else if (grant[i]) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    // Pointer moves just past the winner; holds when nothing is granted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + ptr_t'(1);
        end
    end

    // Registered write port; index and data hold when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_en   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            wb_en <= gnt_any;
            if (gnt_any) begin
                wb_rd   <= ent_rd[gnt_idx];
                wb_data <= ent_data[gnt_idx];
            end
        end
    end

    // Scoreboard update: a same-edge issue beats the writeback clear
    always_comb begin
        pending_nxt = pending;
        if (wb_en) pending_nxt[wb_rd] = 1'b0;
        if (issue_valid && issue_rd != '0) pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Scoreboard state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign rs1_fwd_valid = wb_en && (wb_rd == query_rs1)
                         && (query_rs1 != '0);
    assign rs2_fwd_valid = wb_en && (wb_rd == query_rs2)
                         && (query_rs2 != '0);
    assign rs1_pending   = pending[query_rs1] & ~rs1_fwd_valid;
    assign rs2_pending   = pending[query_rs2] & ~rs2_fwd_valid;
    assign rs1_fwd_data  = wb_data;
    assign rs2_fwd_data  = wb_data;
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Directed bench for the writeback controller: latency, round-robin,
// streaming throughput, scoreboard/bypass, rd==0 and mid-flight reset.
module tb_regfile_writeback_ctrl;
    localparam int NS = 3;
    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk;
    logic          reset;
    logic          issue_valid;
    logic [RW-1:0] issue_rd;
    logic [RW-1:0] query_rs1;
    logic [RW-1:0] query_rs2;
    logic          rs1_pending;
    logic          rs2_pending;
    logic          rs1_fwd_valid;
    logic          rs2_fwd_valid;
    logic [DW-1:0] rs1_fwd_data;
    logic [DW-1:0] rs2_fwd_data;
    logic          wb_en;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;

    int tests = 0;
    int fails = 0;

    regfile_writeback_ctrl_if #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW)
    ) sif ();

    regfile_writeback_ctrl #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .src(sif),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .query_rs1(query_rs1),
        .query_rs2(query_rs2),
        .rs1_pending(rs1_pending),
        .rs2_pending(rs2_pending),
        .rs1_fwd_valid(rs1_fwd_valid),
        .rs2_fwd_valid(rs2_fwd_valid),
        .rs1_fwd_data(rs1_fwd_data),
        .rs2_fwd_data(rs2_fwd_data),
        .wb_en(wb_en),
        .wb_rd(wb_rd),
        .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_src(input int i, input logic v,
                             input logic [RW-1:0] rd,
                             input logic [DW-1:0] d);
        sif.src_valid[i]          = v;
        sif.src_rd[i*RW +: RW]    = rd;
        sif.src_data[i*DW +: DW]  = d;
    endtask

    task automatic idle_src();
        sif.src_valid = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        query_rs1 = 5'd7;
        query_rs2 = 5'd3;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (wb_en !== 1'b0) begin
            fails++; $display("FAIL rst_wb_en: got %b want 0", wb_en);
        end
        tests++;
        if (sif.src_ready !== 3'b000) begin
            fails++;
            $display("FAIL rst_ready: got %b want 000", sif.src_ready);
        end
        tests++;
        if (wb_rd !== 5'd0 || wb_data !== 32'd0) begin
            fails++;
            $display("FAIL rst_wb_bus: got %h/%h want 0/0", wb_rd, wb_data);
        end
        tests++;
        if (rs1_pending !== 1'b0 || rs1_fwd_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_query: got %b%b want 00",
                     rs1_pending, rs1_fwd_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (sif.src_ready !== 3'b111) begin
            fails++;
            $display("FAIL rel_ready: got %b want 111", sif.src_ready);
        end
    endtask

    task automatic test_single();
        query_rs1 = 5'd0;
        query_rs2 = 5'd0;
        @(negedge clk);
        drive_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        tests++;
        if (sif.src_ready[0] !== 1'b1 || wb_en !== 1'b0) begin
            fails++;
            $display("FAIL single_accept: got rdy=%b wb_en=%b want 1/0",
                     sif.src_ready[0], wb_en);
        end
        @(negedge clk);
        idle_src();
        #1;
        tests++;
        if (wb_en !== 1'b0) begin
            fails++; $display("FAIL single_early: got %b want 0", wb_en);
        end
        @(negedge clk);
        #1;
        tests++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL single_wb: got %b/%0d/%h want 1/5/deadbeef",
                     wb_en, wb_rd, wb_data);
        end
        @(negedge clk);
        #1;
        tests++;
        if (wb_en !== 1'b0) begin
            fails++; $display("FAIL single_once: got %b want 0", wb_en);
        end
    endtask

    task automatic test_all_three();
        logic [DW-1:0] exp_d;
        do_reset();
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            drive_src(0, 1'b1, 5'd1, 32'h11);
            drive_src(1, 1'b1, 5'd2, 32'h22);
            drive_src(2, 1'b1, 5'd3, 32'h33);
            @(negedge clk);
            idle_src();
            #1;
            tests++;
            if (sif.src_ready !== 3'b001 || wb_en !== 1'b0) begin
                fails++;
                $display("FAIL burst%0d_ready: got %b/%b want 001/0",
                         b, sif.src_ready, wb_en);
            end
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                #1;
                exp_d = 32'h11 * 32'(j + 1);
                tests++;
                if (wb_en !== 1'b1 || wb_rd !== 5'(j + 1) || wb_data !== exp_d) begin
                    fails++;
                    $display("FAIL burst%0d_wr%0d: got %b/%0d/%h want 1/%0d/%h",
                             b, j, wb_en, wb_rd, wb_data, j + 1, exp_d);
                end
            end
            @(negedge clk);
            #1;
            tests++;
            if (wb_en !== 1'b0) begin
                fails++; $display("FAIL burst%0d_end: got %b want 0", b, wb_en);
            end
        end
    endtask

    task automatic test_mul_stream();
        int            mul_n;
        int            alu_n;
        logic [NS-1:0] r;
        logic [DW-1:0] exp_d;
        logic [RW-1:0] exp_rd;
        mul_n = 0;
        alu_n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive_src(2, 1'b1, 5'd9, 32'h100 + 32'(mul_n));
            #1;
            tests++;
            if (sif.src_ready[2] !== 1'b1) begin
                fails++;
                $display("FAIL stream_ready%0d: got %b want 1", k, sif.src_ready[2]);
            end
            if (k >= 2) begin
                exp_d = 32'h100 + 32'(k) - 32'd2;
                tests++;
                if (wb_en !== 1'b1 || wb_rd !== 5'd9 || wb_data !== exp_d) begin
                    fails++;
                    $display("FAIL stream_wb%0d: got %b/%0d/%h want 1/9/%h",
                             k, wb_en, wb_rd, wb_data, exp_d);
                end
            end
            mul_n++;
        end
        for (int c = 6; c <= 12; c++) begin
            @(negedge clk);
            drive_src(2, 1'b1, 5'd9, 32'h100 + 32'(mul_n));
            drive_src(0, 1'b1, 5'd4, 32'h200 + 32'(alu_n));
            #1;
            r = sif.src_ready;
            if (c >= 7) begin
                if (c % 2 == 1) begin
                    exp_rd = 5'd9;
                    exp_d  = 32'h100 + 32'(5 + (c - 7) / 2);
                end else begin
                    exp_rd = 5'd4;
                    exp_d  = 32'h200 + 32'((c - 8) / 2);
                end
                tests++;
                if (r[2] !== 1'(c % 2 == 0) || r[0] !== 1'(c % 2 == 1)) begin
                    fails++;
                    $display("FAIL mix_ready%0d: got alu=%b mul=%b", c, r[0], r[2]);
                end
                tests++;
                if (wb_en !== 1'b1 || wb_rd !== exp_rd || wb_data !== exp_d) begin
                    fails++;
                    $display("FAIL mix_wb%0d: got %b/%0d/%h want 1/%0d/%h",
                             c, wb_en, wb_rd, wb_data, exp_rd, exp_d);
                end
            end
            if (r[2] === 1'b1) mul_n++;
            if (r[0] === 1'b1) alu_n++;
        end
        @(negedge clk);
        idle_src();
        repeat (4) @(negedge clk);
        #1;
        tests++;
        if (wb_en !== 1'b0) begin
            fails++; $display("FAIL mix_drain: got %b want 0", wb_en);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        query_rs1   = 5'd7;
        query_rs2   = 5'd7;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        tests++;
        if (rs1_pending !== 1'b0) begin
            fails++; $display("FAIL sb_pre: got %b want 0", rs1_pending);
        end
        @(negedge clk);
        issue_valid = 1'b0;
        drive_src(1, 1'b1, 5'd7, 32'h77);
        #1;
        tests++;
        if (rs1_pending !== 1'b1 || rs2_pending !== 1'b1) begin
            fails++;
            $display("FAIL sb_set: got %b%b want 11", rs1_pending, rs2_pending);
        end
        @(negedge clk);
        idle_src();
        #1;
        tests++;
        if (rs1_pending !== 1'b1 || rs1_fwd_valid !== 1'b0) begin
            fails++;
            $display("FAIL sb_wait: got %b%b want 10", rs1_pending, rs1_fwd_valid);
        end
        @(negedge clk);
        #1;
        tests++;
        if (wb_en !== 1'b1 || rs1_fwd_valid !== 1'b1 || rs1_pending !== 1'b0
            || rs1_fwd_data !== 32'h77 || rs2_fwd_valid !== 1'b1) begin
            fails++;
            $display("FAIL sb_fwd: got en=%b fv=%b p=%b d=%h fv2=%b want 1/1/0/77/1",
                     wb_en, rs1_fwd_valid, rs1_pending, rs1_fwd_data, rs2_fwd_valid);
        end
        @(negedge clk);
        #1;
        tests++;
        if (rs1_pending !== 1'b0 || rs1_fwd_valid !== 1'b0) begin
            fails++;
            $display("FAIL sb_clear: got %b%b want 00", rs1_pending, rs1_fwd_valid);
        end
        @(negedge clk);
        issue_valid = 1'b1;
        @(negedge clk);
        issue_valid = 1'b0;
        drive_src(2, 1'b1, 5'd7, 32'h78);
        #1;
        tests++;
        if (rs1_pending !== 1'b1) begin
            fails++; $display("FAIL sb_reissue: got %b want 1", rs1_pending);
        end
        @(negedge clk);
        idle_src();
        @(negedge clk);
        issue_valid = 1'b1;
        #1;
        tests++;
        if (rs1_fwd_valid !== 1'b1 || rs1_pending !== 1'b0 || wb_data !== 32'h78) begin
            fails++;
            $display("FAIL sb_fwd2: got fv=%b p=%b d=%h want 1/0/78",
                     rs1_fwd_valid, rs1_pending, wb_data);
        end
        @(negedge clk);
        issue_valid = 1'b0;
        #1;
        tests++;
        if (rs1_pending !== 1'b1 || rs1_fwd_valid !== 1'b0) begin
            fails++;
            $display("FAIL sb_setwins: got %b%b want 10", rs1_pending, rs1_fwd_valid);
        end
    endtask

    task automatic test_rd0();
        @(negedge clk);
        query_rs1   = 5'd0;
        query_rs2   = 5'd0;
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        drive_src(0, 1'b1, 5'd0, 32'hBAD);
        #1;
        tests++;
        if (sif.src_ready[0] !== 1'b1 || rs1_pending !== 1'b0
            || rs1_fwd_valid !== 1'b0) begin
            fails++;
            $display("FAIL rd0_accept: got %b%b%b want 100",
                     sif.src_ready[0], rs1_pending, rs1_fwd_valid);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            idle_src();
            issue_valid = 1'b0;
            #1;
            tests++;
            if (wb_en !== 1'b0 || wb_data !== 32'h78 || rs1_pending !== 1'b0
                || rs2_fwd_valid !== 1'b0) begin
                fails++;
                $display("FAIL rd0_drop%0d: got en=%b d=%h p=%b fv=%b want 0/78/0/0",
                         j, wb_en, wb_data, rs1_pending, rs2_fwd_valid);
            end
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        issue_valid = 1'b1;
        issue_rd    = 5'd10;
        drive_src(0, 1'b1, 5'd1, 32'hA1);
        @(negedge clk);
        issue_rd = 5'd11;
        drive_src(1, 1'b1, 5'd2, 32'hA2);
        drive_src(2, 1'b1, 5'd3, 32'hA3);
        @(negedge clk);
        issue_valid = 1'b0;
        query_rs1   = 5'd10;
        query_rs2   = 5'd11;
        #1;
        tests++;
        if (wb_en !== 1'b1 || rs1_pending !== 1'b1 || rs2_pending !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre: got %b%b%b want 111",
                     wb_en, rs1_pending, rs2_pending);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (wb_en !== 1'b0 || sif.src_ready !== 3'b000
            || rs1_pending !== 1'b0 || rs2_pending !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst: got en=%b rdy=%b p=%b%b want 0/000/00",
                     wb_en, sif.src_ready, rs1_pending, rs2_pending);
        end
        @(negedge clk);
        idle_src();
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            tests++;
            if (wb_en !== 1'b0) begin
                fails++; $display("FAIL mid_ghost: got %b want 0", wb_en);
            end
        end
        @(negedge clk);
        drive_src(0, 1'b1, 5'd12, 32'hC0);
        drive_src(2, 1'b1, 5'd13, 32'hC2);
        @(negedge clk);
        idle_src();
        @(negedge clk);
        #1;
        tests++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd12 || wb_data !== 32'hC0) begin
            fails++;
            $display("FAIL mid_first: got %b/%0d/%h want 1/12/c0",
                     wb_en, wb_rd, wb_data);
        end
        @(negedge clk);
        #1;
        tests++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd13 || wb_data !== 32'hC2) begin
            fails++;
            $display("FAIL mid_second: got %b/%0d/%h want 1/13/c2",
                     wb_en, wb_rd, wb_data);
        end
    endtask

    initial begin
        reset         = 1'b1;
        issue_valid   = 1'b0;
        issue_rd      = '0;
        query_rs1     = '0;
        query_rs2     = '0;
        sif.src_valid = '0;
        sif.src_rd    = '0;
        sif.src_data  = '0;
        test_reset();
        test_single();
        test_all_three();
        test_mul_stream();
        test_scoreboard();
        test_rd0();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_writeback_ctrl.md
Name: regfile_writeback_ctrl

Overview:
- Writer side of the core's 32x32 register table. Merges completion results from NUM_SRC execution producers (ALU, load, multiply) into the table's single write port.
- Each producer is buffered, arbitrated round-robin, and presented as a registered write strobe.
- A pending-destination scoreboard, with writeback bypass, tells issue logic which source operands are still in flight.

Parameters:
- NUM_SRC, 3, number of producer ports (0=ALU, 1=MEM, 2=MUL).
- DATA_WIDTH, 32, register data width.
- REG_ADDR_WIDTH, 5, register index width (2^REG_ADDR_WIDTH registers).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- src_valid  in  NUM_SRC  producer i has a result.
- src_ready  out  NUM_SRC  producer i result accepted this cycle when valid&ready.
- src_rd  in  NUM_SRC*REG_ADDR_WIDTH  destination index, slice i.
- src_data  in  NUM_SRC*DATA_WIDTH  result data, slice i.
- issue_valid  in  1  issue stage dispatches an instruction writing issue_rd.
- issue_rd  in  REG_ADDR_WIDTH  destination being dispatched.
- query_rs1  in  REG_ADDR_WIDTH  operand 1 index to check.
- query_rs2  in  REG_ADDR_WIDTH  operand 2 index to check.
- rs1_pending  out  1  operand 1 not yet available.
- rs2_pending  out  1  operand 2 not yet available.
- rs1_fwd_valid  out  1  operand 1 is being written this cycle; use rs1_fwd_data.
- rs2_fwd_valid  out  1  same for operand 2.
- rs1_fwd_data  out  DATA_WIDTH  equals wb_data.
- rs2_fwd_data  out  DATA_WIDTH  equals wb_data.
- wb_en  out  1  write strobe to register table.
- wb_rd  out  REG_ADDR_WIDTH  write index.
- wb_data  out  DATA_WIDTH  write data.

Behaviour:
- Reset (async, on assertion): holding buffers empty, pending bits all 0, RR pointer 0, wb_en/wb_rd/wb_data 0. Outputs derived from these are therefore 0: src_ready=0 while reset is high, and pending/fwd outputs=0. In-flight results are discarded mid-operation.
- Holding buffers: one entry {full, rd, data} per source.
  - src_ready[i] = !full[i] | grant[i].
  - On src_valid&src_ready with rd!=0, the entry loads at the edge.
  - rd==0 results are accepted (ready as above) but dropped. No entry, no scoreboard change.
- Arbitration: combinational over full[]. Round-robin starting at pointer p; the first full entry in order p, p+1, ... wins. Exactly one grant or none.
  - On a grant to i, the pointer becomes (i+1) mod NUM_SRC at the edge. With no grant, the pointer holds.
  - A granted entry clears at the edge unless refilled the same edge (grant and accept on the same port both take effect: entry holds the new result).
- Write port: registered. At the edge after a grant, wb_en=1, wb_rd and wb_data come from the granted entry.
  - With no grant, wb_en=0 and wb_rd/wb_data hold their last values.
  - Latency: result accepted at edge T, with no contention, gives wb_en high during cycle T+1..T+2. The table writes at edge T+2.
  - Sustained throughput is one write per cycle.
- Scoreboard: pending[r] sets at the edge when issue_valid & issue_rd==r & r!=0. It clears at the edge when wb_en & wb_rd==r.
  - Set and clear of the same r at the same edge: set wins.
  - pending[0] is always 0.
  - Issue logic guarantees no second issue to an already pending rd. The block need not detect this.
- Query (combinational), for k = 1, 2:
  - rsk_fwd_valid = wb_en & wb_rd==query_rsk & query_rsk!=0.
  - rsk_pending = pending[query_rsk] & !rsk_fwd_valid.
  - rsk_fwd_data = wb_data.
- Ordering: producers may finish out of order across ports. Within one port, results write in acceptance order.

Test Plan:
- Single ALU result rd=5, data=0xDEADBEEF, src_valid[0] high one cycle → src_ready[0]=1; wb_en high exactly one cycle, 2 edges after issue, wb_rd=5, wb_data=0xDEADBEEF.
- All three sources valid in the same cycle (rd 1/2/3, data 0x11/0x22/0x33), pointer=0 → writes appear on 3 consecutive cycles in order 1,2,3. Next simultaneous burst order is 1,2,3 again (pointer wraps to 0).
- Continuous src_valid on MUL only → wb_en high every cycle, src_ready[2] stays 1, data order preserved. Then add ALU → writes alternate ALU/MUL, and src_ready[2] drops to 0 on cycles its entry is full and not granted.
- issue rd=7 → rs1_pending=1 for query_rs1=7. When wb_rd=7 with wb_en → rs1_pending=0, rs1_fwd_valid=1, rs1_fwd_data=wb_data. Next cycle pending bit is clear. Same edge re-issue of rd=7 → pending stays 1.
- Result with rd=0, and issue with rd=0 → accepted, no wb_en, pending/fwd for query 0 always 0.
- Assert reset with all three entries full and pending bits set → wb_en, src_ready, all pending drop immediately. After release the first write occurs only for new inputs, and the pointer starts at 0.
